// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC line-capture controller: register map,
// FSM encoding, STATUS/CTRL bit positions and the LENGTH clamp helper.
package adc_ctrl_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_LENGTH   = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_DATA     = 3'd3;
  localparam logic [2:0] ADDR_LINE_CNT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int CTRL_ARM_BIT    = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_FULL_BIT  = 3;
  localparam int STAT_OVF_BIT   = 4;
  localparam int STAT_DONE_BIT  = 5;

  localparam logic [15:0] LENGTH_RESET = 16'd1024;

  // A zero-length line would never finish, so 0 is promoted to 1.
  function automatic logic [15:0] f_sat_length(input logic [15:0] i_val,
                                               input logic [15:0] i_max);
    logic [15:0] v;
    if (i_val == 16'd0) begin
      v = 16'd1;
    end else if (i_val > i_max) begin
      v = i_max;
    end else begin
      v = i_val;
    end
    return v;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Show-ahead sample FIFO with synchronous flush and occupancy output.
// A push while full is accepted only when a pop happens in the same cycle.
module adc_sample_fifo
  import adc_ctrl_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [SAMPLE_W-1:0] i_wdata,
  output logic [SAMPLE_W-1:0] o_rdata,
  output logic                o_empty,
  output logic                o_full,
  output logic [AW:0]         o_level
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_level;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_MAX);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Avalon-MM controlled ADC line capture: arm, wait for trigger edge,
// collect LENGTH samples into a FIFO, then flag done / raise irq.
module adc_capture_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_LEN    = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic [15:0] adc_data,
  input  logic        adc_valid,
  input  logic        trigger,
  output logic        irq
);

  localparam int          LW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_e      r_state;
  logic [15:0] r_length;
  logic [15:0] r_sample_cnt;
  logic [15:0] r_line_cnt;
  logic        r_irq_en;
  logic        r_done;
  logic        r_overflow;
  logic        r_trig_d;
  logic [15:0] r_readdata;
  logic        r_irq;

  state_e      w_state_nxt;
  logic [15:0] w_length_nxt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_line_nxt;
  logic        w_irq_en_nxt;
  logic        w_done_nxt;
  logic        w_ovf_nxt;
  logic [15:0] w_rdata_nxt;
  logic [15:0] w_status;

  logic          w_ctrl_wr;
  logic          w_clear;
  logic          w_arm;
  logic          w_len_wr;
  logic          w_trig_rise;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_evt;
  logic [15:0]   w_cnt_inc;
  logic [15:0]   w_head;
  logic          w_empty;
  logic          w_full;
  logic [LW-1:0] w_level;

  assign w_ctrl_wr   = write && (address == ADDR_CTRL);
  assign w_clear     = w_ctrl_wr && writedata[CTRL_CLEAR_BIT];
  assign w_arm       = w_ctrl_wr && writedata[CTRL_ARM_BIT] && !writedata[CTRL_CLEAR_BIT];
  assign w_len_wr    = write && (address == ADDR_LENGTH);
  assign w_trig_rise = trigger && !r_trig_d;
  // Only samples seen while already capturing count; the trigger cycle's sample is not part of the line.
  assign w_push      = adc_valid && (r_state == ST_CAPTURE) && !w_clear;
  assign w_pop       = read && (address == ADDR_DATA) && !w_empty;
  assign w_ovf_evt   = w_push && w_full && !w_pop;
  assign w_cnt_inc   = r_sample_cnt + 16'd1;

  adc_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_flush (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (adc_data),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );

  // Next-state and control-register update logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_length_nxt = r_length;
    w_cnt_nxt    = r_sample_cnt;
    w_line_nxt   = r_line_cnt;
    w_done_nxt   = r_done;
    w_ovf_nxt    = r_overflow;
    if (w_ctrl_wr) begin
      w_irq_en_nxt = writedata[CTRL_IRQ_EN_BIT];
    end else begin
      w_irq_en_nxt = r_irq_en;
    end
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 16'd0;
      w_done_nxt  = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else begin
      if (w_ovf_evt) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_ovf_nxt = r_overflow;
      end
      if (w_len_wr && (r_state == ST_IDLE)) begin
        w_length_nxt = f_sat_length(writedata, MAX_LEN_W);
      end else begin
        w_length_nxt = r_length;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_arm) begin
            w_state_nxt = ST_ARMED;
            w_done_nxt  = 1'b0;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_ARMED: begin
          if (w_trig_rise) begin
            w_state_nxt = ST_CAPTURE;
            w_cnt_nxt   = 16'd0;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (adc_valid) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == r_length) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
              w_line_nxt  = r_line_cnt + 16'd1;
            end else begin
              w_state_nxt = ST_CAPTURE;
            end
          end else begin
            w_cnt_nxt = r_sample_cnt;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // STATUS word assembly and address-selected read mux.
  always_comb begin
    w_status                 = 16'd0;
    w_status[1:0]            = r_state;
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_OVF_BIT]   = r_overflow;
    w_status[STAT_DONE_BIT]  = r_done;
    w_status[15:8]           = 8'(w_level);
    case (address)
      ADDR_CTRL:     w_rdata_nxt = {13'd0, r_irq_en, 2'd0};
      ADDR_LENGTH:   w_rdata_nxt = r_length;
      ADDR_STATUS:   w_rdata_nxt = w_status;
      ADDR_DATA:     w_rdata_nxt = w_empty ? 16'd0 : w_head;
      ADDR_LINE_CNT: w_rdata_nxt = r_line_cnt;
      default:       w_rdata_nxt = 16'd0;
    endcase
  end

  // Register bank, FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_length     <= LENGTH_RESET;
      r_sample_cnt <= 16'd0;
      r_line_cnt   <= 16'd0;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_trig_d     <= 1'b0;
      r_readdata   <= 16'd0;
      r_irq        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_length     <= w_length_nxt;
      r_sample_cnt <= w_cnt_nxt;
      r_line_cnt   <= w_line_nxt;
      r_irq_en     <= w_irq_en_nxt;
      r_done       <= w_done_nxt;
      r_overflow   <= w_ovf_nxt;
      r_trig_d     <= trigger;
      r_readdata   <= w_rdata_nxt;
      r_irq        <= w_done_nxt && w_irq_en_nxt;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl (FIFO_DEPTH=32, MAX_LEN=4096).
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic [15:0] adc_data = 16'd0;
  logic        adc_valid = 1'b0;
  logic        trigger = 1'b0;
  logic        irq;

  int total = 0;
  int bad = 0;

  adc_capture_ctrl #(.FIFO_DEPTH(32), .MAX_LEN(4096)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .trigger   (trigger),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; write = 1'b1;
    tick;
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address = a; read = 1'b1;
    tick;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic sample(input logic [15:0] d);
    adc_data = d; adc_valid = 1'b1;
    tick;
    adc_valid = 1'b0;
  endtask

  task automatic trig_pulse;
    trigger = 1'b1;
    tick;
    trigger = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    reset_n = 1'b0;
    tick; tick;
    reset_n = 1'b1;
    tick;
    total++; if (readdata !== 16'h0000) begin bad++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 16'h0000); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd(3'd1, v);
    total++; if (v !== 16'h0400) begin bad++; $display("FAIL reset_length got=%h exp=%h", v, 16'h0400); end
    rd(3'd2, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL reset_status got=%h exp=%h", v, 16'h0004); end
    rd(3'd4, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_linecnt got=%h exp=%h", v, 16'h0000); end
    rd(3'd5, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL unmapped_addr got=%h exp=%h", v, 16'h0000); end
    rd(3'd3, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_data_empty got=%h exp=%h", v, 16'h0000); end
  endtask

  task automatic test_basic_line;
    logic [15:0] v;
    logic [15:0] exp_d;
    wr(3'd1, 16'd4);
    rd(3'd1, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL length_wr got=%h exp=%h", v, 16'h0004); end
    wr(3'd0, 16'h0001);
    rd(3'd2, v);
    total++; if (v !== 16'h0005) begin bad++; $display("FAIL status_armed got=%h exp=%h", v, 16'h0005); end
    trig_pulse;
    rd(3'd2, v);
    total++; if (v !== 16'h0006) begin bad++; $display("FAIL status_capture got=%h exp=%h", v, 16'h0006); end
    for (int i = 0; i < 4; i++) sample(16'h0011 + 16'(i));
    rd(3'd2, v);
    total++; if (v !== 16'h0423) begin bad++; $display("FAIL status_done got=%h exp=%h", v, 16'h0423); end
    for (int i = 0; i < 4; i++) begin
      exp_d = 16'h0011 + 16'(i);
      rd(3'd3, v);
      total++; if (v !== exp_d) begin bad++; $display("FAIL data_pop%0d got=%h exp=%h", i, v, exp_d); end
    end
    rd(3'd3, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL data_fifth got=%h exp=%h", v, 16'h0000); end
    rd(3'd4, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL linecnt_1 got=%h exp=%h", v, 16'h0001); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_disabled got=%b exp=0", irq); end
  endtask

  task automatic test_length_limits;
    logic [15:0] v;
    wr(3'd1, 16'd7);
    rd(3'd1, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL length_ignored_done got=%h exp=%h", v, 16'h0004); end
    wr(3'd0, 16'h0002);
    wr(3'd1, 16'd0);
    rd(3'd1, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL length_zero got=%h exp=%h", v, 16'h0001); end
    wr(3'd1, 16'hFFFF);
    rd(3'd1, v);
    total++; if (v !== 16'h1000) begin bad++; $display("FAIL length_sat got=%h exp=%h", v, 16'h1000); end
    wr(3'd1, 16'd4096);
    rd(3'd1, v);
    total++; if (v !== 16'h1000) begin bad++; $display("FAIL length_max got=%h exp=%h", v, 16'h1000); end
  endtask

  task automatic test_overflow;
    logic [15:0] v;
    wr(3'd1, 16'd40);
    wr(3'd0, 16'h0001);
    trig_pulse;
    for (int i = 0; i < 40; i++) sample(16'h0100 + 16'(i));
    rd(3'd2, v);
    total++; if (v !== 16'h203B) begin bad++; $display("FAIL overflow_status got=%h exp=%h", v, 16'h203B); end
    rd(3'd4, v);
    total++; if (v !== 16'h0002) begin bad++; $display("FAIL linecnt_2 got=%h exp=%h", v, 16'h0002); end
    rd(3'd3, v);
    total++; if (v !== 16'h0100) begin bad++; $display("FAIL overflow_head got=%h exp=%h", v, 16'h0100); end
    wr(3'd0, 16'h0002);
    rd(3'd2, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL clear_after_ovf got=%h exp=%h", v, 16'h0004); end
  endtask

  task automatic test_full_push_pop;
    logic [15:0] v;
    wr(3'd1, 16'd40);
    wr(3'd0, 16'h0001);
    trig_pulse;
    for (int i = 0; i < 32; i++) sample(16'h0200 + 16'(i));
    rd(3'd2, v);
    total++; if (v !== 16'h200A) begin bad++; $display("FAIL full_status got=%h exp=%h", v, 16'h200A); end
    adc_data = 16'hAAAA; adc_valid = 1'b1; address = 3'd3; read = 1'b1;
    tick;
    adc_valid = 1'b0; read = 1'b0;
    total++; if (readdata !== 16'h0200) begin bad++; $display("FAIL full_pop_data got=%h exp=%h", readdata, 16'h0200); end
    rd(3'd2, v);
    total++; if (v !== 16'h200A) begin bad++; $display("FAIL full_push_pop_status got=%h exp=%h", v, 16'h200A); end
    rd(3'd3, v);
    total++; if (v !== 16'h0201) begin bad++; $display("FAIL full_next_head got=%h exp=%h", v, 16'h0201); end
    wr(3'd0, 16'h0002);
  endtask

  task automatic test_irq;
    logic [15:0] v;
    wr(3'd1, 16'd2);
    wr(3'd0, 16'h0005);
    rd(3'd0, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL ctrl_irq_en got=%h exp=%h", v, 16'h0004); end
    trig_pulse;
    sample(16'h0031);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
    sample(16'h0032);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
    rd(3'd4, v);
    total++; if (v !== 16'h0003) begin bad++; $display("FAIL linecnt_3 got=%h exp=%h", v, 16'h0003); end
    wr(3'd0, 16'h0005);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rearm got=%b exp=0", irq); end
    rd(3'd2, v);
    total++; if (v !== 16'h0201) begin bad++; $display("FAIL rearm_status got=%h exp=%h", v, 16'h0201); end
  endtask

  task automatic test_clear_mid_capture;
    logic [15:0] v;
    wr(3'd0, 16'h0002);
    wr(3'd1, 16'd10);
    wr(3'd0, 16'h0001);
    trig_pulse;
    for (int i = 0; i < 3; i++) sample(16'h0040 + 16'(i));
    wr(3'd0, 16'h0001);
    rd(3'd2, v);
    total++; if (v !== 16'h0302) begin bad++; $display("FAIL arm_ignored_capture got=%h exp=%h", v, 16'h0302); end
    trig_pulse;
    sample(16'h0043);
    rd(3'd2, v);
    total++; if (v !== 16'h0402) begin bad++; $display("FAIL trig_ignored_capture got=%h exp=%h", v, 16'h0402); end
    wr(3'd0, 16'h0002);
    rd(3'd2, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL clear_mid_status got=%h exp=%h", v, 16'h0004); end
    rd(3'd4, v);
    total++; if (v !== 16'h0003) begin bad++; $display("FAIL clear_mid_linecnt got=%h exp=%h", v, 16'h0003); end
    trig_pulse;
    sample(16'h0055);
    rd(3'd2, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL trig_no_arm got=%h exp=%h", v, 16'h0004); end
  endtask

  task automatic test_reset_mid_capture;
    logic [15:0] v;
    wr(3'd1, 16'd8);
    wr(3'd0, 16'h0001);
    trig_pulse;
    sample(16'h0061);
    sample(16'h0062);
    reset_n = 1'b0;
    tick;
    total++; if (readdata !== 16'h0000) begin bad++; $display("FAIL rst_mid_readdata got=%h exp=%h", readdata, 16'h0000); end
    reset_n = 1'b1;
    rd(3'd2, v);
    total++; if (v !== 16'h0004) begin bad++; $display("FAIL rst_mid_status got=%h exp=%h", v, 16'h0004); end
    rd(3'd4, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL rst_mid_linecnt got=%h exp=%h", v, 16'h0000); end
    rd(3'd1, v);
    total++; if (v !== 16'h0400) begin bad++; $display("FAIL rst_mid_length got=%h exp=%h", v, 16'h0400); end
  endtask

  initial begin
    test_reset;
    test_basic_line;
    test_length_limits;
    test_overflow;
    test_full_push_pop;
    test_irq;
    test_clear_mid_capture;
    test_reset_mid_capture;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
